// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA stream loader: FSM state encoding,
// operand count and operand index ordering used on the input stream.
package rsa_pkg;

    localparam int OP_W_DEF   = 1024;
    localparam int WORD_W_DEF = 32;
    localparam int NUM_OPS    = 5;

    localparam int OP_MSG   = 0;
    localparam int OP_EXP   = 1;
    localparam int OP_N     = 2;
    localparam int OP_RMODN = 3;
    localparam int OP_R2    = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // Index width that stays legal when a field holds a single value.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rsa_operand_bank.sv
// Five OP_W operand registers (msg, exp, n, rmodn, r2modn), each written one
// WORD_W slot at a time from an (operand index, slot, write enable) triple.
module rsa_operand_bank
    import rsa_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int SLOT_W = clog2_min1(OP_W / WORD_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_we,
    input  logic [2:0]        i_op_idx,
    input  logic [SLOT_W-1:0] i_slot,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [OP_W-1:0]   o_msg,
    output logic [OP_W-1:0]   o_exp,
    output logic [OP_W-1:0]   o_n,
    output logic [OP_W-1:0]   o_rmodn,
    output logic [OP_W-1:0]   o_r2modn
);

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        logic [OP_W-1:0] r_op;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_op <= '0;
            end else if (i_we && (i_op_idx == 3'(gi))) begin
                r_op[i_slot*WORD_W +: WORD_W] <= i_wdata;
            end
        end
    end

    assign o_msg    = g_op[OP_MSG].r_op;
    assign o_exp    = g_op[OP_EXP].r_op;
    assign o_n      = g_op[OP_N].r_op;
    assign o_rmodn  = g_op[OP_RMODN].r_op;
    assign o_r2modn = g_op[OP_R2].r_op;

endmodule

// File: rtl/rsa_stream_loader.sv
// Word-serial front end for montgomery_exp: streams operands in, pulses start,
// waits for done and streams the result out. RSA_LOADER_CYCLE_COUNT_EN adds a WAIT cycle counter.
module rsa_stream_loader
    import rsa_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              core_start,
    output logic              core_encryp_mode,
    output logic [OP_W-1:0]   core_msg,
    output logic [OP_W-1:0]   core_exp,
    output logic [OP_W-1:0]   core_n,
    output logic [OP_W-1:0]   core_rmodn,
    output logic [OP_W-1:0]   core_r2modn,
    input  logic [OP_W-1:0]   core_result,
    input  logic              core_done
`ifdef RSA_LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int WPO       = OP_W / WORD_W;
    localparam int JOB_WORDS = NUM_OPS * WPO;
    localparam int CNT_W     = clog2_min1(JOB_WORDS);
    localparam int SLOT_W    = clog2_min1(WPO);

    localparam logic [CNT_W-1:0] CNT_JOB_LAST = CNT_W'(JOB_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_OUT_LAST = CNT_W'(WPO - 1);
    localparam logic [CNT_W-1:0] CNT_WPO      = CNT_W'(WPO);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mode;
    logic [OP_W-1:0]   r_result;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_bank_we;
    logic [2:0]        w_op_idx;
    logic [SLOT_W-1:0] w_slot;

    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_bank_we = w_in_hs;
    assign w_op_idx  = 3'(r_cnt / CNT_WPO);
    assign w_slot    = SLOT_W'(r_cnt % CNT_WPO);

    assign out_data         = r_result[WORD_W-1:0];
    assign core_encryp_mode = r_mode;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        core_start   = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == CNT_JOB_LAST)) begin
                    w_state_next = START;
                end
            end
            START: begin
                core_start   = 1'b1;
                busy         = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    w_state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (r_cnt == CNT_OUT_LAST);
                if (out_ready && (r_cnt == CNT_OUT_LAST)) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
    end

    // One counter serves both directions: job word index in LOAD, result word index in UNLOAD.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_hs) begin
                        if (r_cnt == '0) begin
                            r_mode <= in_mode;
                        end
                        r_cnt <= (r_cnt == CNT_JOB_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        r_result <= core_result;
                    end
                end
                UNLOAD: begin
                    if (w_out_hs) begin
                        r_result <= r_result >> WORD_W;
                        r_cnt    <= (r_cnt == CNT_OUT_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    rsa_operand_bank #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .SLOT_W (SLOT_W)
    ) u_bank (
        .clk      (clk),
        .resetn   (resetn),
        .i_we     (w_bank_we),
        .i_op_idx (w_op_idx),
        .i_slot   (w_slot),
        .i_wdata  (in_data),
        .o_msg    (core_msg),
        .o_exp    (core_exp),
        .o_n      (core_n),
        .o_rmodn  (core_rmodn),
        .o_r2modn (core_r2modn)
    );

`ifdef RSA_LOADER_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    // Counts WAIT cycles including the done cycle; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cycle_count <= '0;
        end else if (r_state == START) begin
            r_cycle_count <= '0;
        end else if ((r_state == WAIT) && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_rsa_stream_loader.sv
// Scoreboard bench for rsa_stream_loader: loads jobs, models the core, checks
// operands, start timing, result stream, backpressure, spurious done and reset.
module tb_rsa_stream_loader;

    localparam int WORD_W = 32;
    localparam int OP_W   = 1024;
    localparam int WPO    = OP_W / WORD_W;
    localparam int NOPS   = 5;
    localparam int JOBW   = NOPS * WPO;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              core_start;
    logic              core_encryp_mode;
    logic [OP_W-1:0]   core_msg, core_exp, core_n, core_rmodn, core_r2modn;
    logic [OP_W-1:0]   core_result;
    logic              core_done;
`ifdef RSA_LOADER_CYCLE_COUNT_EN
    logic [31:0]       cycle_count;
`endif

    always #5 clk = ~clk;

    rsa_stream_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_mode          (in_mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .core_start       (core_start),
        .core_encryp_mode (core_encryp_mode),
        .core_msg         (core_msg),
        .core_exp         (core_exp),
        .core_n           (core_n),
        .core_rmodn       (core_rmodn),
        .core_r2modn      (core_r2modn),
        .core_result      (core_result),
        .core_done        (core_done)
`ifdef RSA_LOADER_CYCLE_COUNT_EN
        ,
        .cycle_count      (cycle_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_ops[NOPS][WPO];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] get_op(input int j);
        case (j)
            0: return core_msg;
            1: return core_exp;
            2: return core_n;
            3: return core_rmodn;
            default: return core_r2modn;
        endcase
    endfunction

    // Drives one job; ends at the negedge of the START cycle with start-side checks done.
    task automatic load_job(input int base, input bit mode, input bit bubbles, input int spur_at);
        int  k = 0;
        int  guard = 0;
        bit  tog = 1'b0;
        logic [OP_W-1:0] op;
        while (k < JOBW && guard < 1000) begin
            @(negedge clk);
            guard++;
            core_done = 1'b0;
            chk($sformatf("in_ready_w%0d", k), 64'(in_ready), 64'd1);
            chk($sformatf("no_out_w%0d", k), 64'(out_valid), 64'd0);
            if (bubbles && tog) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_mode  = ~mode;
            end else begin
                in_valid = 1'b1;
                in_data  = base + k;
                in_mode  = (k == 0) ? mode : ~mode;
                if (k == spur_at) core_done = 1'b1;
                if (in_ready) begin
                    model_ops[k / WPO][k % WPO] = base + k;
                    k++;
                end
            end
            tog = ~tog;
        end
        if (k != JOBW) chk("load_timeout", 64'(k), 64'(JOBW));
        @(negedge clk);
        in_valid  = 1'b0;
        core_done = 1'b0;
        chk("start_pulse", 64'(core_start), 64'd1);
        chk("busy_start", 64'(busy), 64'd1);
        chk("in_ready_start", 64'(in_ready), 64'd0);
        chk("mode", 64'(core_encryp_mode), 64'(mode));
        for (int j = 0; j < NOPS; j++) begin
            op = get_op(j);
            for (int w = 0; w < WPO; w++)
                chk($sformatf("op%0d_w%0d", j, w), 64'(op[w*WORD_W +: WORD_W]), 64'(model_ops[j][w]));
        end
        $display("job base %h loaded mode %0d", base, mode);
    endtask

    // Core model: done lands in the 10th WAIT cycle; ends at negedge of first UNLOAD cycle.
    task automatic run_core(input logic [31:0] rbase, input int rstep);
        logic [OP_W-1:0] res;
        @(negedge clk);
        chk("start_one_cycle", 64'(core_start), 64'd0);
        chk("busy_wait", 64'(busy), 64'd1);
        repeat (9) begin
            @(negedge clk);
            chk("no_out_wait", 64'(out_valid), 64'd0);
        end
        for (int k = 0; k < WPO; k++) begin
            res[k*WORD_W +: WORD_W] = rbase + 32'(k * rstep);
            exp_q.push_back(rbase + 32'(k * rstep));
        end
        core_result = res;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = '1;
        chk("out_valid_after_done", 64'(out_valid), 64'd1);
        chk("busy_unload", 64'(busy), 64'd0);
`ifdef RSA_LOADER_CYCLE_COUNT_EN
        chk("cycle_count", 64'(cycle_count), 64'd10);
`endif
    endtask

    task automatic unload(input bit bp);
        int n = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit rdy;
        while (n < WPO && guard < 4 * WPO) begin
            guard++;
            chk($sformatf("out_valid_o%0d", n), 64'(out_valid), 64'd1);
            if (exp_q.size() > 0)
                chk($sformatf("out_data_o%0d", n), 64'(out_data), 64'(exp_q[0]));
            chk($sformatf("out_last_o%0d", n), 64'(out_last), 64'(n == WPO - 1));
            rdy = bp ? tog : 1'b1;
            tog = ~tog;
            out_ready = rdy;
            if (rdy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("unload_count", 64'(n), 64'(WPO));
        chk("out_done", 64'(out_valid), 64'd0);
        chk("back_to_load", 64'(in_ready), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("job unloaded %0d words bp %0d", n, bp);
    endtask

    initial begin
        logic [OP_W-1:0] op;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_mode     = 1'b0;
        out_ready   = 1'b0;
        core_done   = 1'b0;
        core_result = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mode", 64'(core_encryp_mode), 64'd0);
`ifdef RSA_LOADER_CYCLE_COUNT_EN
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
`endif

        load_job(0, 1'b1, 1'b0, -1);
        chk("msg_lsw", 64'(core_msg[31:0]), 64'h0);
        chk("exp_lsw", 64'(core_exp[31:0]), 64'h20);
        chk("r2_msw", 64'(core_r2modn[1023:992]), 64'h9F);
        run_core(32'hA000_0000, 1);
        unload(1'b0);

        load_job(32'h5000, 1'b0, 1'b1, 50);
        run_core(32'hB000_0000, 3);
        unload(1'b1);

        load_job(32'h3000, 1'b1, 1'b0, -1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn      = 1'b1;
        core_done   = 1'b1;
        core_result = '1;
        @(negedge clk);
        core_done = 1'b0;
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_in_ready", 64'(in_ready), 64'd1);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_mode", 64'(core_encryp_mode), 64'd0);
        for (int j = 0; j < NOPS; j++) begin
            op = get_op(j);
            chk($sformatf("rstw_op%0d_zero", j), 64'(|op), 64'd0);
        end
        repeat (3) begin
            @(negedge clk);
            chk("rstw_no_out", 64'(out_valid), 64'd0);
        end
        $display("reset during WAIT handled");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
